// File: rtl/mem_access_unit.sv
// Memory-stage unit: passes ALU results to writeback or runs a load/store
// over a req/ack data-memory port, stalling upstream while an access is open.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_val,
    input  logic [REG_W-1:0]  m_dst,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              w_valid,
    output logic [REG_W-1:0]  w_dst,
    output logic [DATA_W-1:0] w_data,
    output logic              misalign_err,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                load_q;
    logic [REG_W-1:0]    dst_q;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                w_valid_q;
    logic [REG_W-1:0]    w_dst_q;
    logic [DATA_W-1:0]   w_data_q;
    logic                mis_q;
    logic                to_q;

    logic                is_mem;
    logic                misaligned;

    assign is_mem     = m_read | m_write;
    assign misaligned = (m_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            load_q    <= 1'b0;
            dst_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            w_valid_q <= 1'b0;
            w_dst_q   <= '0;
            w_data_q  <= '0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            w_valid_q <= 1'b0;
            w_dst_q   <= '0;
            w_data_q  <= '0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (m_valid) begin
                        if (!is_mem) begin
                            w_valid_q <= 1'b1;
                            w_dst_q   <= m_dst;
                            w_data_q  <= DATA_W'(m_addr);
                        end else if (misaligned) begin
                            w_valid_q <= 1'b1;
                            mis_q     <= 1'b1;
                        end else begin
                            // Write wins when both read and write are set.
                            state_q <= BUSY;
                            cnt_q   <= '0;
                            load_q  <= ~m_write;
                            dst_q   <= m_dst;
                            req_q   <= 1'b1;
                            we_q    <= m_write;
                            addr_q  <= m_addr;
                            wdata_q <= m_write ? m_val : '0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                        w_valid_q <= 1'b1;
                        w_dst_q   <= load_q ? dst_q : '0;
                        w_data_q  <= load_q ? dmem_rdata : '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                        w_valid_q <= 1'b1;
                        to_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == BUSY);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign w_valid      = w_valid_q;
    assign w_dst        = w_dst_q;
    assign w_data       = w_data_q;
    assign misalign_err = mis_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected writebacks,
// a negedge monitor pops and compares every w_valid pulse.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_read, m_write;
    logic [31:0] m_addr, m_val;
    logic [4:0]  m_dst;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        w_valid;
    logic [4:0]  w_dst;
    logic [31:0] w_data;
    logic        misalign_err, timeout_err;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W(32), .ADDR_W(32), .REG_W(5), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_read(m_read), .m_write(m_write),
        .m_addr(m_addr), .m_val(m_val), .m_dst(m_dst),
        .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .w_valid(w_valid), .w_dst(w_dst), .w_data(w_data),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v,
                        input logic mi, input logic t);
        exp_t e;
        e.dst = d; e.data = v; e.mis = mi; e.to = t;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] v, input logic [4:0] d);
        m_valid = 1'b1; m_read = rd; m_write = wr;
        m_addr = a; m_val = v; m_dst = d;
    endtask

    task automatic idle_in();
        m_valid = 1'b0; m_read = 1'b0; m_write = 1'b0;
        m_addr = '0; m_val = '0; m_dst = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (w_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_w_valid: got dst=%0d data=%h expected none",
                             w_dst, w_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("w_dst", 32'(w_dst), 32'(e.dst));
                    chk("w_data", w_data, e.data);
                    chk("misalign_err", 32'(misalign_err), 32'(e.mis));
                    chk("timeout_err", 32'(timeout_err), 32'(e.to));
                end
            end else if (misalign_err || timeout_err) begin
                checks++;
                failures++;
                $display("FAIL stray_err: got mis=%0b to=%0b expected 0 0",
                         misalign_err, timeout_err);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_in();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_w_valid", 32'(w_valid), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: ALU pass-through
        drive(0, 0, 32'h1234, 0, 5'd5);
        push(5'd5, 32'h1234, 0, 0);
        tick();
        idle_in();
        chk("alu_stall", 32'(stall), 0);
        chk("alu_w_valid", 32'(w_valid), 1);

        // 2: load, ack after 3 wait cycles
        drive(1, 0, 32'h100, 0, 5'd7);
        push(5'd7, 32'hDEADBEEF, 0, 0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(stall), 1);
            chk("ld_req", 32'(dmem_req), 1);
            chk("ld_addr", dmem_addr, 32'h100);
            chk("ld_we", 32'(dmem_we), 0);
            tick();
        end
        chk("ld_stall4", 32'(stall), 1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        chk("ld_done_stall", 32'(stall), 0);
        chk("ld_done_req", 32'(dmem_req), 0);

        // 3: store acked in first BUSY cycle
        drive(0, 1, 32'h40, 32'hA5A5, 5'd9);
        push(5'd0, 32'h0, 0, 0);
        tick();
        idle_in();
        chk("st_we", 32'(dmem_we), 1);
        chk("st_wdata", dmem_wdata, 32'hA5A5);
        chk("st_stall", 32'(stall), 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("st_done_stall", 32'(stall), 0);

        // 4: misaligned load
        drive(1, 0, 32'h102, 0, 5'd4);
        push(5'd0, 32'h0, 1, 0);
        tick();
        idle_in();
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_stall", 32'(stall), 0);
        tick();
        chk("mis_req2", 32'(dmem_req), 0);

        // 5: timeout with TIMEOUT=4
        drive(1, 0, 32'h200, 0, 5'd3);
        push(5'd0, 32'h0, 0, 1);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(dmem_req), 1);
            tick();
        end
        chk("to_req_end", 32'(dmem_req), 0);
        chk("to_stall_end", 32'(stall), 0);

        // ack on the limit cycle wins; read+write acts as store
        drive(1, 1, 32'h300, 32'h77, 5'd6);
        push(5'd0, 32'h0, 0, 0);
        tick();
        idle_in();
        chk("rw_we", 32'(dmem_we), 1);
        chk("rw_wdata", dmem_wdata, 32'h77);
        tick(); tick(); tick();
        chk("lim_req", 32'(dmem_req), 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("lim_req_end", 32'(dmem_req), 0);

        // ALU op held during BUSY is consumed only after completion
        drive(1, 0, 32'h400, 0, 5'd0);
        push(5'd0, 32'hCAFE0001, 0, 0);
        push(5'd9, 32'h55, 0, 0);
        tick();
        drive(0, 0, 32'h55, 0, 5'd9);
        tick();
        chk("hold_stall", 32'(stall), 1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        tick();
        idle_in();

        // ack while IDLE ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_req", 32'(dmem_req), 0);
        tick();

        // 6: reset mid-access
        drive(1, 0, 32'h500, 0, 5'd2);
        tick();
        idle_in();
        chk("rst6_req_pre", 32'(dmem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst6_req", 32'(dmem_req), 0);
        chk("rst6_stall", 32'(stall), 0);
        tick();
        rst = 1'b0;
        tick();
        drive(0, 0, 32'hBEEF, 0, 5'd11);
        push(5'd11, 32'hBEEF, 0, 0);
        tick();
        idle_in();
        tick(); tick();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
